rx_ctrl: RTL
============

RX_CTRL -- requirements
Module: rx_ctrl

Interface
REQ-001 Parameter: DATA_BITS, default 8, number of data bits per serial frame (legal range 1..15).
REQ-002 Parameter: PERIOD_BITS, default 8, width of bit_period.
REQ-003 Port: clk  in  1  single system clock; all state updates on the rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: start_detected  in  1  one-cycle pulse from the start-bit edge detector.
REQ-006 Port: serial_in  in  1  synchronized serial line.
REQ-007 Port: bit_period  in  PERIOD_BITS  clocks per bit; captured on frame start.
REQ-008 Port: shift_strobe  out  1  one-cycle pulse at each data-bit centre.
REQ-009 Port: load_buffer  out  1  one-cycle pulse when a frame completes with a valid stop bit.
REQ-010 Port: framing_error  out  1  sticky flag for a bad stop bit.
REQ-011 Port: busy  out  1  high in every state except IDLE.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP, LOAD.
REQ-013 IDLE SHALL go to START on the edge that samples start_detected=1, capture bit_period into period_q, and clear both counters.
REQ-014 period_q SHALL be forced to 2 when the captured bit_period is below 2.
REQ-015 START SHALL sample serial_in exactly period_q>>1 cycles after entry; 0 -> DATA, 1 -> IDLE (false start, no outputs).
REQ-016 DATA SHALL pulse shift_strobe every period_q cycles, counting DATA_BITS strobes, with the first strobe period_q cycles after START's sample.
REQ-017 After strobe number DATA_BITS the FSM SHALL enter STOP, which samples serial_in period_q cycles after the last strobe.
REQ-018 At the STOP sample: serial_in=1 -> LOAD; serial_in=0 -> IDLE with framing_error set.
REQ-019 LOAD SHALL assert load_buffer for exactly one cycle, then return to IDLE.
REQ-020 framing_error SHALL clear on the next start_detected accepted in IDLE; otherwise it holds.
REQ-021 start_detected outside IDLE SHALL be ignored.
REQ-022 bit_period changes mid-frame SHALL NOT affect the current frame.
REQ-023 shift_strobe and load_buffer SHALL never be high in the same cycle.
REQ-024 The bit-period counter SHALL roll over at period_q.
REQ-025 The bit counter SHALL be ceil(log2(DATA_BITS+1)) bits wide.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, shift_strobe=0, load_buffer=0, framing_error=0, busy=0, clear both counters, and set period_q=2.
REQ-027 rst asserted mid-frame SHALL abort the frame, with no load_buffer pulse afterwards.
REQ-028 Normal operation SHALL resume on the first rising edge after rst falls.

Structure
REQ-029 Package rx_pkg SHALL hold the state enum type and the DATA_BITS default.
REQ-030 One sub-module, rx_bit_timer, SHALL be instantiated twice: once for bits, once for cycles-per-bit.
REQ-031 rx_bit_timer SHALL be a clearable, enable-gated rollover counter with a programmable rollover value and a rollover_flag output, reset by rst.

Verification
REQ-032 Valid frame: bit_period=10, DATA_BITS=8, start_detected at edge 0, serial_in=0 then data 0xA5 LSB-first, stop=1.
  - shift_strobe at edges 15,25,...,85.
  - load_buffer at edge 96.
  - framing_error=0.
REQ-033 False start: serial_in returns to 1 before edge 5 -> back to IDLE, busy=0, no strobe, no load_buffer.
REQ-034 Framing error: as REQ-032 but stop=0 -> framing_error=1 from edge 96, no load_buffer; the next start_detected clears it.
REQ-035 Reset mid-frame: rst pulsed at edge 40 -> all outputs 0 immediately; no pulses before the next start_detected.
REQ-036 Boundary: bit_period=1 -> behaves as 2, strobes every 2 cycles; a start_detected pulse during DATA is ignored.
REQ-037 Period change: bit_period changed to 4 at edge 30 of a bit_period=10 frame -> strobe spacing stays 10.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types and defaults for the serial receive controller.
// The state enum is used by the controller and its debug port.
package rx_pkg;

  localparam int DATA_BITS_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    LOAD
  } rx_state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// Clearable, enable-gated rollover counter.
// Counts 0..rollover_value-1; rollover_flag marks the enabled cycle that wraps to 0.
module rx_bit_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] rollover_value,
  output logic [WIDTH-1:0] count,
  output logic             rollover_flag
);

  assign rollover_flag = enable && (count == rollover_value - WIDTH'(1));

  // clear wins over enable so the owner can restart a count on any cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= rollover_flag ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/rx_ctrl.sv
// Serial frame receive controller: start-bit qualification, data-bit centre
// strobes, stop-bit check, buffer load pulse and sticky framing error.
module rx_ctrl
  import rx_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEFAULT,
  parameter int PERIOD_BITS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_detected,
  input  logic                           serial_in,
  input  logic [PERIOD_BITS-1:0]         bit_period,
  output logic                           shift_strobe,
  output logic                           load_buffer,
  output logic                           framing_error,
  output logic                           busy,
  output rx_state_t                      state,
  output logic [$clog2(DATA_BITS+1)-1:0] bit_count
);

  localparam int BIT_W = $clog2(DATA_BITS + 1);

  rx_state_t              state_q, state_d;
  logic [PERIOD_BITS-1:0] period_q;
  logic [PERIOD_BITS-1:0] half_point;
  logic [PERIOD_BITS-1:0] cyc_count;
  logic                   fe_q;
  logic                   accept, fe_set;
  logic                   cyc_clear, cyc_en, cyc_flag;
  logic                   bit_clear, bit_flag;

  // Start bit is checked at its centre: half a period after entering START.
  assign half_point    = (period_q >> 1) - PERIOD_BITS'(1);
  assign state         = state_q;
  assign framing_error = fe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      period_q <= PERIOD_BITS'(2);
      fe_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        period_q <= (bit_period < PERIOD_BITS'(2)) ? PERIOD_BITS'(2) : bit_period;
      end
      if (accept) begin
        fe_q <= 1'b0;
      end else if (fe_set) begin
        fe_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    fe_set       = 1'b0;
    cyc_clear    = 1'b0;
    cyc_en       = 1'b0;
    bit_clear    = 1'b0;
    shift_strobe = 1'b0;
    load_buffer  = 1'b0;
    busy         = 1'b1;
    case (state_q)
      IDLE: begin
        busy      = 1'b0;
        cyc_clear = 1'b1;
        bit_clear = 1'b1;
        if (start_detected) begin
          accept  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        cyc_en = 1'b1;
        if (cyc_count == half_point) begin
          cyc_clear = 1'b1;
          state_d   = serial_in ? IDLE : DATA;
        end
      end
      DATA: begin
        cyc_en       = 1'b1;
        shift_strobe = cyc_flag;
        if (cyc_flag && bit_flag) begin
          state_d = STOP;
        end
      end
      STOP: begin
        cyc_en = 1'b1;
        if (cyc_flag) begin
          if (serial_in) begin
            state_d = LOAD;
          end else begin
            state_d = IDLE;
            fe_set  = 1'b1;
          end
        end
      end
      LOAD: begin
        load_buffer = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  rx_bit_timer #(.WIDTH(PERIOD_BITS)) u_cycle_timer (
    .clk           (clk),
    .rst           (rst),
    .clear         (cyc_clear),
    .enable        (cyc_en),
    .rollover_value(period_q),
    .count         (cyc_count),
    .rollover_flag (cyc_flag)
  );

  // Advances once per strobe; its flag marks the final data bit.
  rx_bit_timer #(.WIDTH(BIT_W)) u_bit_timer (
    .clk           (clk),
    .rst           (rst),
    .clear         (bit_clear),
    .enable        (shift_strobe),
    .rollover_value(BIT_W'(DATA_BITS)),
    .count         (bit_count),
    .rollover_flag (bit_flag)
  );

endmodule
